cla_pipelined: RTL

- Parametrised, pipelined successor to the team's 8-bit behavioural carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into GROUP-bit lookahead groups, one group per pipeline stage.
- The inter-group carry is registered between stages, so any WIDTH closes timing at full clock rate.
- Valid/ready streaming interface with full backpressure; sits between operand producers and datapath consumers (ALU, accumulators).

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_group.sv | 39 +++
 rtl/cla_pipelined.sv | 115 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared configuration for the pipelined carry-lookahead adder.
// Default geometry plus helpers used at elaboration time.
package cla_pkg;

  localparam int CLA_WIDTH = 8;
  localparam int CLA_GROUP = 4;

  function automatic int cla_ngrp(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cla_cfg_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead adder slice.
// Every carry is a flat sum-of-products of generate/propagate terms.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar i = 0; i < GROUP; i++) begin : g_carry
    logic [i+1:0] terms;
    assign terms[0] = cin & (&p[i:0]);
    for (genvar j = 0; j <= i; j++) begin : g_term
      if (j == i) begin : g_last
        assign terms[j+1] = g[j];
      end else begin : g_prop
        assign terms[j+1] = g[j] & (&p[i:j+1]);
      end
    end
    assign c[i+1] = |terms;
  end

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_pipelined.sv
// Pipelined add/subtract: one lookahead group per stage, carry registered
// between stages, valid/ready stream with a single global stall enable.
module cla_pipelined
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = cla_ngrp(WIDTH, GROUP);

  if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_cfg_err
    $error("cla_pipelined: WIDTH must be a multiple of GROUP");
  end

  logic en;

  logic [NGRP:1]    sv;
  logic [NGRP:1]    sc;
  logic [WIDTH-1:0] sa [1:NGRP];
  logic [WIDTH-1:0] sb [1:NGRP];
  logic [WIDTH-1:0] ss [1:NGRP];
  logic [WIDTH-1:0] sn [1:NGRP];
  logic [NGRP:1]    gco;
  logic [NGRP:1]    gcm;

  logic [NGRP:1]    v_q;
  logic [NGRP:1]    c_q;
  logic [NGRP:1]    m_q;
  logic [WIDTH-1:0] a_q [1:NGRP];
  logic [WIDTH-1:0] b_q [1:NGRP];
  logic [WIDTH-1:0] s_q [1:NGRP];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 1; k <= NGRP; k++) begin : g_stg
    logic [GROUP-1:0] gsum;
    logic [WIDTH-1:0] mrg;

    if (k == 1) begin : g_in
      assign sv[k] = in_valid;
      assign sa[k] = a;
      assign sb[k] = b ^ {WIDTH{sub}};
      assign sc[k] = sub | cin;
      assign ss[k] = '0;
    end else begin : g_prev
      assign sv[k] = v_q[k-1];
      assign sa[k] = a_q[k-1];
      assign sb[k] = b_q[k-1];
      assign sc[k] = c_q[k-1];
      assign ss[k] = s_q[k-1];
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (sa[k][k*GROUP-1 -: GROUP]),
      .b    (sb[k][k*GROUP-1 -: GROUP]),
      .cin  (sc[k]),
      .sum  (gsum),
      .cout (gco[k]),
      .cmsb (gcm[k])
    );

    // Splice this group's sum bits into the deskewed lower result.
    always_comb begin
      mrg = ss[k];
      mrg[k*GROUP-1 -: GROUP] = gsum;
    end

    assign sn[k] = mrg;
  end

  // Advance every stage, bubbles included, only when the output can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      m_q <= '0;
      for (int k = 1; k <= NGRP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= sv;
      c_q <= gco;
      m_q <= gcm;
      for (int k = 1; k <= NGRP; k++) begin
        a_q[k] <= sa[k];
        b_q[k] <= sb[k];
        s_q[k] <= sn[k];
      end
    end
  end

  assign out_valid = v_q[NGRP];
  assign sum       = s_q[NGRP];
  assign cout      = c_q[NGRP];
  assign ovf       = c_q[NGRP] ^ m_q[NGRP];

endmodule
